rom_port_arbiter: RTL
=====================

Name: rom_port_arbiter

Overview:
- Shares the single instruction ROM read port between two requesters: the instruction fetch unit (port F) and the constant/table-load path of the execute stage (port D).
- Accepts at most one request per cycle with round-robin arbitration and drives the ROM read strobe and address from registers.
- Tracks in-flight reads through a tag pipeline matched to the ROM read latency, and returns each word to the requester that issued it.
- Supports pausing new issues and flushing in-flight fetches on a branch.

Parameters:
- DATA_W, 14, ROM word width.
- ADDR_W, 12, ROM address width.
- ROM_LAT, 2, cycles from the cycle rom_rd=1 to the cycle rom_data is valid (legal range 1..7).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- pause  in  1  1 = grant nothing new; in-flight reads still complete.
- f_flush  in  1  discard all in-flight port-F reads (branch taken).
- f_req  in  1  port F request.
- f_addr  in  ADDR_W  port F address; held stable while f_req=1 and f_gnt=0.
- f_gnt  out  1  combinational; request accepted at the coming edge.
- f_rvalid  out  1  registered one-cycle pulse; f_rdata is valid.
- f_rdata  out  DATA_W  returned word for port F.
- d_req  in  1  port D request.
- d_addr  in  ADDR_W  port D address; same hold rule as port F.
- d_gnt  out  1  combinational accept for port D.
- d_rvalid  out  1  registered one-cycle pulse.
- d_rdata  out  DATA_W  returned word for port D.
- rom_rd  out  1  registered ROM read strobe.
- rom_addr  out  ADDR_W  registered ROM address.
- rom_data  in  DATA_W  ROM read data.
- busy  out  1  1 while rom_rd=1 or any tag is valid.

Behaviour:
- Reset (reset=0, asynchronous):
  - rom_rd=0, rom_addr=0.
  - f_rvalid=0, d_rvalid=0, f_rdata=0, d_rdata=0.
  - All tags cleared; round-robin pointer = F (F has priority).
- Grant logic (combinational):
  - No grant when pause=1.
  - With pause=0 and only one req high, that port is granted.
  - If both are high, the port named by the pointer wins.
  - When f_flush=1, f_gnt is forced to 0; d may still be granted.
  - At most one gnt is high per cycle.
- Handshake:
  - A request is accepted at the rising edge ending a cycle with gnt=1.
  - The requester may change addr or drop req after that edge.
  - Pulling req low without a gnt is allowed; no state is kept for it.
- Issue: on the accept edge, rom_rd<=1 and rom_addr<=granted addr. Otherwise rom_rd<=0 and rom_addr holds its value.
- Pointer update: after an accepted grant, the pointer moves to the other port. It is unchanged when nothing is granted.
- Tag pipeline:
  - ROM_LAT+1 stages, each holding {valid, id}.
  - Stage 0 loads {accept, granted id} on each edge; each stage shifts by one per cycle.
  - The last stage lines up with the cycle rom_data is valid.
- Latency:
  - gnt in cycle c gives rom_rd=1 in cycle c+1 and rom_data valid in cycle c+1+ROM_LAT.
  - rvalid/rdata are registered, so they appear in cycle c+2+ROM_LAT (c+4 at default).
- Return:
  - When the last stage is valid, rom_data is registered into the matching rdata and its rvalid is pulsed for one cycle.
  - rdata holds its value after rvalid drops.
- Throughput: back-to-back grants are allowed, one per cycle. Responses come back in issue order, one per cycle.
- Flush:
  - On an edge with f_flush=1, every valid tag with id=F is cleared in all stages.
  - If the last stage is cleared at that edge, that fetch's data is not returned: f_rvalid=0 next cycle.
  - Port D tags are unaffected.
  - A flush with no in-flight fetch has no effect.
- Pause: stops grants only. The tag pipeline and returns keep running.
- Reset mid-operation: all in-flight reads are dropped with no rvalid pulses; the pointer returns to F.

Test Plan:
- F only, f_addr=0x010 at cycle 0 with ROM returning 0x1A5 -> f_gnt in cycle 0, rom_rd=1 and rom_addr=0x010 in cycle 1, f_rvalid=1 with f_rdata=0x1A5 in cycle 4; d_rvalid stays 0.
- f_req and d_req held high for 4 cycles -> grants alternate F,D,F,D; responses alternate f_rvalid/d_rvalid in cycles 4..7, each carrying its own address's data.
- Fetches at 0x020 and 0x021 in cycles 0-1, D at 0x300 in cycle 2, f_flush=1 in cycle 3 -> no f_rvalid in cycles 4-5; d_rvalid=1 in cycle 6 with the word at 0x300.
- pause=1 for cycles 2-4 with f_req held high -> f_gnt=0 during the pause; a grant issued before the pause still returns; the next grant comes in cycle 5.
- reset pulsed low in cycle 2 with 2 reads in flight -> all outputs 0 immediately, no rvalid after release; the first grant after release goes to F when both ports request.
- f_flush=1 and f_req=1 together with d_req=0 -> no grant and rom_rd=0 next cycle.

Source files
------------

// File: rtl/rom_port_arbiter.sv
// rtl/rom_port_arbiter.sv - round-robin arbiter sharing one ROM read port between fetch (F) and data (D)
module rom_port_arbiter #(
    parameter int DATA_W  = 14,
    parameter int ADDR_W  = 12,
    parameter int ROM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pause,
    input  logic              f_flush,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              rom_rd,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              busy
);

    // Requester ids carried in the tag pipeline; the pointer uses the same encoding.
    localparam logic ID_F = 1'b0;
    localparam logic ID_D = 1'b1;

    logic              ptr;
    logic              f_ok;
    logic              accept;
    logic              gnt_id;
    logic [ROM_LAT:0]  tag_v;
    logic [ROM_LAT:0]  tag_id;
    logic              last_v;
    logic              last_id;

    // A fetch request is ignored while a branch flush is in progress.
    assign f_ok    = f_req && !f_flush;
    assign accept  = f_gnt || d_gnt;
    assign gnt_id  = d_gnt ? ID_D : ID_F;
    assign last_v  = tag_v[ROM_LAT];
    assign last_id = tag_id[ROM_LAT];
    assign busy    = rom_rd || (|tag_v);

    // Combinational grant: pause blocks all, pointer breaks ties, at most one grant.
    always_comb begin
        f_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!pause) begin
            if (f_ok && (!d_req || ptr == ID_F)) begin
                f_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end
        end
    end

    // Register the ROM strobe/address and rotate the pointer away from the winner.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rom_rd   <= 1'b0;
            rom_addr <= '0;
            ptr      <= ID_F;
        end else begin
            rom_rd <= accept;
            if (accept) begin
                rom_addr <= d_gnt ? d_addr : f_addr;
                ptr      <= ~gnt_id;
            end
        end
    end

    // Tag shift register; stage ROM_LAT lines up with valid rom_data. Flush kills F tags in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_v  <= '0;
            tag_id <= '0;
        end else begin
            tag_v[0]  <= accept;
            tag_id[0] <= gnt_id;
            for (int k = 1; k <= ROM_LAT; k++) begin
                tag_v[k]  <= tag_v[k-1] && !(f_flush && tag_id[k-1] == ID_F);
                tag_id[k] <= tag_id[k-1];
            end
        end
    end

    // Steer returning data to its requester; a fetch reaching the end during a flush is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            f_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            f_rdata  <= '0;
            d_rdata  <= '0;
        end else begin
            f_rvalid <= last_v && last_id == ID_F && !f_flush;
            d_rvalid <= last_v && last_id == ID_D;
            if (last_v && last_id == ID_F && !f_flush) begin
                f_rdata <= rom_data;
            end
            if (last_v && last_id == ID_D) begin
                d_rdata <= rom_data;
            end
        end
    end

endmodule
